chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: WIDTH-bit operands are summed
//   CHUNK bits per clock, LSB chunk first, with the carry held in a register
//   between chunks. It trades latency for area in wide datapaths.
//   valid/ready handshakes on input and output let it sit between pipeline stages.
//   Adds subtract mode, carry-in, carry-out and signed-overflow reporting.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK   4  bits processed per cycle; 1 <= CHUNK <= WIDTH
//   (derived) NCH = WIDTH/CHUNK  chunk cycles per operation
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a, b, cin, sub are valid
//   in_ready   out  1      block can accept an operation (IDLE only)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin   1: a-b-cin
//   out_valid  out  1      sum/cout/ovf valid
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      raw carry out of the MSB (for sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow: carry into MSB XOR carry out
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0,
//     sum=0, cout=0, ovf=0, operand/carry/chunk-index registers=0.
//   - States: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready, latch A=a, B=(sub ? ~b : b) and
//     carry=(sub ? ~cin : cin). Clear idx. Go to RUN.
//   - RUN: in_ready=0. Each cycle, add chunk idx of A and B to the carry.
//     Write CHUNK sum bits into sum[idx*CHUNK +: CHUNK], register the chunk carry,
//     then increment idx. On the last chunk (idx==NCH-1), capture cout and set
//     ovf from the MSB carry-in/carry-out. Go to DONE.
//   - DONE: out_valid=1. sum/cout/ovf are held stable until out_valid&&out_ready,
//     then return to IDLE. in_ready rises on the next cycle; there is no overlap.
//   - Latency: the accept edge is T. out_valid is high after edge T+NCH.
//     A result can be consumed no earlier than T+NCH; throughput is 1 op per NCH+2 cycles.
//   - Inputs are ignored outside IDLE. out_ready is ignored outside DONE.
//   - CHUNK==WIDTH: RUN lasts exactly one cycle.
//   - sum is undefined-but-stable during RUN. Consumers read it only with out_valid.
//   - rst_n asserted mid-RUN or mid-DONE aborts the operation. No result is emitted.
// STRUCTURE
//   - Shared package adder_pkg:
//       * state encoding constants ST_IDLE / ST_RUN / ST_DONE (2 bits)
//       * clog2 helper for the idx width
//   - Sub-module chunk_adder #(CHUNK): combinational CHUNK-bit ripple adder built
//     from the team's full-adder cell. Ports (s, cout, c_msb_in, a, b, cin); it
//     exports the carry into its MSB for ovf.
//   - Top module: FSM, operand/carry registers, chunk mux, result register.
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//   1. a=0xFFFF b=0x0001 cin=0 sub=0 -> sum=0x0000 cout=1 ovf=0, out_valid at +4.
//   2. a=0x7FFF b=0x0001 cin=0 sub=0 -> sum=0x8000 cout=0 ovf=1.
//   3. a=0x0003 b=0x0005 cin=0 sub=1 -> sum=0xFFFE cout=0 ovf=0.
//      a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF ovf=1.
//   4. Backpressure: hold out_ready=0 for 10 cycles -> out_valid, sum and cout are stable.
//      in_ready stays 0 and a new in_valid is not accepted. Accepted 1 cycle after out_ready=1.
//   5. Reset mid-op: drop rst_n during the 2nd RUN cycle -> every output takes its reset
//      value immediately. No out_valid follows; the next op a=0x1234 b=0x1111 gives 0x2345.
//   6. Build WIDTH=CHUNK=4: a=0xF b=0x1 cin=1 -> sum=0x1 cout=1, out_valid at +1.
//      Random back-to-back ops checked against a+b+cin / a-b-cin in both configs.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encoding and a
// ceiling-log2 helper used to size the chunk index.
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exports the carry into its MSB so
// the caller can derive signed overflow.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/sub: WIDTH-bit operands summed CHUNK bits per clock, LSB
// first, with valid/ready handshakes on both sides.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IDXW = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [IDXW-1:0]  idx_q,       idx_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK-1:0] s_chunk_c;
  logic             co_chunk_c;
  logic             cmsb_chunk_c;

  // Chunk mux: select the slice currently being summed.
  always_comb begin
    a_chunk_c = a_q[int'(idx_q) * CHUNK +: CHUNK];
    b_chunk_c = b_q[int'(idx_q) * CHUNK +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .s        (s_chunk_c),
    .cout     (co_chunk_c),
    .c_msb_in (cmsb_chunk_c),
    .a        (a_chunk_c),
    .b        (b_chunk_c),
    .cin      (carry_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Subtraction is a + ~b + ~cin, so only the operand latch differs.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub ? ~cin : cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[int'(idx_q) * CHUNK +: CHUNK] = s_chunk_c;
        carry_d = co_chunk_c;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDX_LAST) begin
          cout_d      = co_chunk_c;
          ovf_d       = cmsb_chunk_c ^ co_chunk_c;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: a 16/4 build and a 4/4 build driven through
// a shared stimulus path and checked against an arithmetic reference model.
module tb_chunked_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sel4;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;

  logic        iv16, iv4, or16, or4;
  logic        ir16, ir4, ov16, ov4;
  logic [15:0] s16;
  logic [3:0]  s4;
  logic [3:0]  a4, b4;
  logic        c16, c4, o16, o4;

  logic        ir_sel, ov_sel, c_sel, o_sel;
  logic [15:0] s_sel;

  int total;
  int bad;

  assign iv16 = in_valid & ~sel4;
  assign iv4  = in_valid & sel4;
  assign or16 = out_ready & ~sel4;
  assign or4  = out_ready & sel4;
  assign a4   = a[3:0];
  assign b4   = b[3:0];

  assign ir_sel = sel4 ? ir4 : ir16;
  assign ov_sel = sel4 ? ov4 : ov16;
  assign s_sel  = sel4 ? {12'h000, s4} : s16;
  assign c_sel  = sel4 ? c4 : c16;
  assign o_sel  = sel4 ? o4 : o16;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(c16), .ovf(o16)
  );

  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(c4), .ovf(o4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic su,
                                output logic [15:0] s, output logic c, output logic o);
    longint m, half, ua, ub, u, sa, sb, r, cl;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(av) & (m - 1);
    ub   = longint'(bv) & (m - 1);
    cl   = ci ? 1 : 0;
    u    = su ? (ua - ub - cl) : (ua + ub + cl);
    s    = 16'(u & (m - 1));
    c    = su ? (u >= 0) : (u >= m);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    r    = su ? (sa - sb - cl) : (sa + sb + cl);
    o    = (r >= half) || (r < -half);
  endfunction

  // Full transaction on the selected build; returns result and accept->valid latency.
  task automatic run_op(input bit w4, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic su,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int lat);
    int n;
    sel4 = w4;
    n = 0;
    @(negedge clk);
    while (!ir_sel && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(ir_sel), 32'd1);
    a = av; b = bv; cin = ci; sub = su;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!ov_sel && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rs = s_sel; rc = c_sel; ro = o_sel;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("ov_drop", 32'(ov_sel), 32'd0);
    chk("ir_rise", 32'(ir_sel), 32'd1);
  endtask

  typedef struct {
    bit          w4;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
    int          elat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] rs, es;
    logic        rc, ro, ec, eo;
    int          lat, n;

    total = 0; bad = 0;
    in_valid = 0; out_ready = 0; sel4 = 0;
    a = '0; b = '0; cin = 0; sub = 0;

    vecs[0] = '{0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 4};
    vecs[1] = '{0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 4};
    vecs[2] = '{0, 16'h0003, 16'h0005, 0, 1, 16'hFFFE, 0, 0, 4};
    vecs[3] = '{0, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 4};
    vecs[4] = '{0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 4};
    vecs[5] = '{0, 16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0, 4};
    vecs[6] = '{1, 16'h000F, 16'h0001, 1, 0, 16'h0001, 1, 0, 1};
    vecs[7] = '{1, 16'h0008, 16'h0001, 0, 1, 16'h0007, 1, 1, 1};

    rst_n = 1'b0;
    #12;
    chk("rst_in_ready",  32'(ir16), 32'd1);
    chk("rst_out_valid", 32'(ov16), 32'd0);
    chk("rst_sum",       32'(s16),  32'd0);
    chk("rst_cout",      32'(c16),  32'd0);
    chk("rst_ovf",       32'(o16),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].w4, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i),  32'(rs),  32'(vecs[i].es));
      chk($sformatf("vec%0d_cout", i), 32'(rc),  32'(vecs[i].ec));
      chk($sformatf("vec%0d_ovf", i),  32'(ro),  32'(vecs[i].eo));
      chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].elat));
    end

    // Backpressure: result held, new request ignored until the slot frees up
    sel4 = 0;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b1;
    n = 0;
    while (!ov16 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    model(16, 16'hABCD, 16'h1111, 1'b1, 1'b0, es, ec, eo);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", 32'(ov16), 32'd1);
      chk("bp_sum",       32'(s16),  32'(es));
      chk("bp_cout",      32'(c16),  32'(ec));
      chk("bp_in_ready",  32'(ir16), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_ov", 32'(ov16), 32'd0);
    chk("bp_release_ir", 32'(ir16), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_second_accept", 32'(ir16), 32'd0);
    n = 0;
    while (!ov16 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_second_lat", 32'(n), 32'd4);
    model(16, 16'h0F0F, 16'h0101, 1'b0, 1'b1, es, ec, eo);
    chk("bp_second_sum", 32'(s16), 32'(es));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  32'(ir16), 32'd1);
    chk("abort_out_valid", 32'(ov16), 32'd0);
    chk("abort_sum",       32'(s16),  32'd0);
    chk("abort_cout",      32'(c16),  32'd0);
    chk("abort_ovf",       32'(o16),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (ov16) n++;
    end
    chk("abort_no_result", 32'(n), 32'd0);
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("post_abort_sum", 32'(rs), 32'h2345);

    // Random back-to-back operations on both builds
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 30; k++) begin
        logic [15:0] ra, rb;
        logic        rci, rsu;
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rci = 1'($urandom);
        rsu = 1'($urandom);
        if (w == 1) begin
          ra = ra & 16'h000F;
          rb = rb & 16'h000F;
        end
        run_op(w == 1, ra, rb, rci, rsu, rs, rc, ro, lat);
        model((w == 1) ? 4 : 16, ra, rb, rci, rsu, es, ec, eo);
        chk($sformatf("rnd%0d_%0d_sum", w, k),  32'(rs),  32'(es));
        chk($sformatf("rnd%0d_%0d_cout", w, k), 32'(rc),  32'(ec));
        chk($sformatf("rnd%0d_%0d_ovf", w, k),  32'(ro),  32'(eo));
        chk($sformatf("rnd%0d_%0d_lat", w, k),  32'(lat), (w == 1) ? 32'd1 : 32'd4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
